mem2_access_stage: RTL

Parametrised second memory pipeline stage: it latches the execute/memory-1 bundle and runs a blocking DCache access for loads and stores. It aligns and sign/zero-extends load data and generates byte enables and replicated store data. It also detects misaligned accesses, handles flushes that arrive during an in-flight access, and back-pressures upstream while the cache is busy. It sits between the memory-1 stage and writeback and drives the DCache request port directly.

---
 rtl/mem2_access_stage.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem2_access_stage.sv
// Second memory pipeline stage: latches the memory-1 bundle, runs a blocking
// DCache access for loads/stores, aligns/extends load data and builds store lanes.
module mem2_access_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [DATA_W-1:0]   ex_result_in,
    input  logic [DATA_W-1:0]   store_data_in,
    input  logic [IDX_W-1:0]    rd_index_in,
    input  logic [2:0]          number_length_in,
    input  logic [1:0]          memory_rw_in,
    input  logic                writeback_valid_in,
    input  logic                writeback_src_in,
    input  logic                stall_in,
    input  logic                flush_in,
    output logic [DATA_W-1:0]   ex_result,
    output logic [IDX_W-1:0]    rd_index,
    output logic                writeback_valid,
    output logic                writeback_src,
    output logic [DATA_W-1:0]   mem_result,
    output logic                misalign,
    output logic                clear,
    output logic                stall_out,
    output logic [ADDR_W-1:0]   p_addr,
    output logic                p_addr_valid,
    output logic [1:0]          cache_rw,
    output logic [DATA_W-1:0]   cache_write,
    output logic [DATA_W/8-1:0] cache_byte_en,
    input  logic                cache_ready,
    input  logic [DATA_W-1:0]   cache_read
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    // Element size as log2(bytes); a doubleword on a 32-bit datapath acts as a word.
    function automatic logic [1:0] size_of(input logic [2:0] nl);
        logic [1:0] sz;
        sz = nl[1:0];
        if (DATA_W == 32 && sz == 2'b11) sz = 2'b10;
        return sz;
    endfunction

    function automatic logic is_aligned(input logic [1:0] sz, input logic [2:0] off);
        logic ok;
        case (sz)
            2'b00:   ok = 1'b1;
            2'b01:   ok = (off[0] == 1'b0);
            2'b10:   ok = (off[1:0] == 2'b00);
            default: ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

    logic [0:0]        state;
    logic [DATA_W-1:0] store_data_q;
    logic [2:0]        number_length_q;
    logic [1:0]        memory_rw_q;
    logic              kill;

    // Input-side decode for the accept decision.
    logic [2:0] off_in;
    logic       mem_op_in;
    logic       misalign_in;

    assign off_in      = 3'(ex_result_in[OFF_W-1:0]);
    assign mem_op_in   = (memory_rw_in == 2'b01) || (memory_rw_in == 2'b10);
    assign misalign_in = mem_op_in && !is_aligned(size_of(number_length_in), off_in);

    // Latched-side decode drives the cache request and load extraction.
    logic [2:0]        off_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [7:0]        elem_be;
    logic [7:0]        be_shift;
    logic [DATA_W-1:0] rd_shifted;
    logic [DATA_W-1:0] load_ext;

    assign off_q  = 3'(ex_result[OFF_W-1:0]);
    assign size_q = size_of(number_length_q);
    assign sign_q = ~number_length_q[2];

    always_comb begin
        case (size_q)
            2'b00:   elem_be = 8'h01;
            2'b01:   elem_be = 8'h03;
            2'b10:   elem_be = 8'h0F;
            default: elem_be = 8'hFF;
        endcase
        be_shift = elem_be << off_q;
    end

    always_comb begin
        case (size_q)
            2'b00:   cache_write = {BE_W{store_data_q[7:0]}};
            2'b01:   cache_write = {(BE_W/2){store_data_q[15:0]}};
            2'b10:   cache_write = {(DATA_W/32){store_data_q[31:0]}};
            default: cache_write = store_data_q;
        endcase
    end

    always_comb begin
        rd_shifted = cache_read >> {off_q, 3'b000};
        case (size_q)
            2'b00:   load_ext = sign_q ? DATA_W'($signed(rd_shifted[7:0]))
                                       : DATA_W'(rd_shifted[7:0]);
            2'b01:   load_ext = sign_q ? DATA_W'($signed(rd_shifted[15:0]))
                                       : DATA_W'(rd_shifted[15:0]);
            2'b10:   load_ext = sign_q ? DATA_W'($signed(rd_shifted[31:0]))
                                       : DATA_W'(rd_shifted[31:0]);
            default: load_ext = rd_shifted;
        endcase
    end

    assign p_addr       = ex_result[ADDR_W-1:0];
    assign p_addr_valid = (state == ACCESS);
    assign stall_out    = (state == ACCESS);
    assign cache_rw     = (state == ACCESS) ? memory_rw_q : 2'b00;

    always_comb begin
        cache_byte_en = '0;
        if (state == ACCESS) begin
            if (memory_rw_q == 2'b01) cache_byte_en = '1;
            else                      cache_byte_en = be_shift[BE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= IDLE;
            ex_result       <= '0;
            store_data_q    <= '0;
            rd_index        <= '0;
            number_length_q <= '0;
            memory_rw_q     <= '0;
            writeback_valid <= 1'b0;
            writeback_src   <= 1'b0;
            mem_result      <= '0;
            misalign        <= 1'b0;
            clear           <= 1'b0;
            kill            <= 1'b0;
        end else begin
            clear <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_in) begin
                        writeback_valid <= 1'b0;
                        memory_rw_q     <= 2'b00;
                        clear           <= 1'b1;
                    end else if (!stall_in) begin
                        ex_result       <= ex_result_in;
                        store_data_q    <= store_data_in;
                        rd_index        <= rd_index_in;
                        number_length_q <= number_length_in;
                        memory_rw_q     <= memory_rw_in;
                        writeback_src   <= writeback_src_in;
                        writeback_valid <= writeback_valid_in && !misalign_in;
                        misalign        <= misalign_in;
                        kill            <= 1'b0;
                        if (mem_op_in && !misalign_in) state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // A flush cannot abandon the request; remember it until completion.
                    if (flush_in) kill <= 1'b1;
                    if (cache_ready) begin
                        state <= IDLE;
                        kill  <= 1'b0;
                        if (kill || flush_in) begin
                            writeback_valid <= 1'b0;
                            clear           <= 1'b1;
                        end else if (memory_rw_q == 2'b01) begin
                            mem_result <= load_ext;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
